// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: turns the asynchronous PLL lock flag into a clean
// synchronous system reset, a ready flag, a divided clock-enable tick and a
// saturating lock-loss counter, all in the PLL output clock domain.
//
// Ports:
//   i_clock            PLL output clock; all logic on its rising edge
//   i_reset            synchronous, active-high block reset
//   i_locked           PLL lock indication, asynchronous to i_clock
//   o_sys_reset        registered system reset, active high (low only in RUN)
//   o_ready            registered ready flag, high only in RUN
//   o_ce_tick          registered one-cycle enable pulse every CE_DIV RUN cycles
//   o_lock_loss_count  saturating count of lock losses seen while in RUN
//
// Parameters:
//   SYNC_STAGES    flops in the lock synchronizer chain (>=2)
//   STABLE_CYCLES  cycles lock must stay high before the reset hold (>=1)
//   HOLD_CYCLES    extra cycles the reset is held after lock is stable (>=1)
//   CE_DIV         o_ce_tick period in clock cycles (>=1)

module pll_reset_sequencer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 16,
    parameter int CE_DIV        = 120
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_locked,
    output logic       o_sys_reset,
    output logic       o_ready,
    output logic       o_ce_tick,
    output logic [7:0] o_lock_loss_count
);

    // One counter serves both STABILIZE and HOLD, so it is sized for the
    // larger of the two terminal values.
    localparam int CNT_MAX = (STABLE_CYCLES > HOLD_CYCLES) ?
                             STABLE_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int DIV_W   = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CE_DIV - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABILIZE = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [DIV_W-1:0]       r_div;
    logic                   r_sys_reset;
    logic                   r_ready;
    logic                   r_ce_tick;
    logic [7:0]             r_loss_cnt;

    // ------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------
    logic                   w_locked_s;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [DIV_W-1:0]       w_div_nxt;
    logic                   w_tick_nxt;
    logic                   w_loss_evt;
    logic [7:0]             w_loss_nxt;

    // Only the last synchronizer stage is ever looked at.
    assign w_locked_s = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Sequencing state machine: next state and shared cycle counter
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_loss_evt  = 1'b0;

        unique case (r_state)
            WAIT_LOCK: begin
                if (w_locked_s) begin
                    w_state_nxt = STABILIZE;
                    w_cnt_nxt   = '0;
                end
            end

            STABILIZE: begin
                if (!w_locked_s) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == STAB_LAST) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end

            HOLD: begin
                if (!w_locked_s) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end

            RUN: begin
                // Only a loss from RUN counts; drops during the
                // qualification phases just restart the sequence.
                if (!w_locked_s) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                    w_loss_evt  = 1'b1;
                end
            end

            default: begin
                w_state_nxt = WAIT_LOCK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Clock-enable divider
    // ------------------------------------------------------------------
    // r_div is held at 0 outside RUN, so the first RUN cycle is position 1
    // and the tick lands on RUN cycle CE_DIV. With CE_DIV=1 the compare is
    // always true and the tick stays high for all of RUN.
    always_comb begin
        w_div_nxt  = '0;
        w_tick_nxt = 1'b0;
        if (w_state_nxt == RUN) begin
            if (r_div == DIV_LAST) begin
                w_div_nxt  = '0;
                w_tick_nxt = 1'b1;
            end else begin
                w_div_nxt  = r_div + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating lock-loss counter
    // ------------------------------------------------------------------
    always_comb begin
        w_loss_nxt = r_loss_cnt;
        if (w_loss_evt && (r_loss_cnt != 8'hFF)) begin
            w_loss_nxt = r_loss_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    // Outputs are decoded from the next state so they change on the same
    // edge as the state itself.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync      <= '0;
            r_state     <= WAIT_LOCK;
            r_cnt       <= '0;
            r_div       <= '0;
            r_sys_reset <= 1'b1;
            r_ready     <= 1'b0;
            r_ce_tick   <= 1'b0;
            r_loss_cnt  <= 8'd0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], i_locked};
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_div       <= w_div_nxt;
            r_sys_reset <= (w_state_nxt != RUN);
            r_ready     <= (w_state_nxt == RUN);
            r_ce_tick   <= w_tick_nxt;
            r_loss_cnt  <= w_loss_nxt;
        end
    end

    assign o_sys_reset       = r_sys_reset;
    assign o_ready           = r_ready;
    assign o_ce_tick         = r_ce_tick;
    assign o_lock_loss_count = r_loss_cnt;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Testbench for pll_reset_sequencer: two instances (CE_DIV=5 and CE_DIV=1)
// share one stimulus stream and are checked every cycle against a model.

module tb_pll_reset_sequencer;

    localparam int SYNC = 2;
    localparam int ST   = 8;
    localparam int HO   = 4;

    logic clk;
    logic rst;
    logic lk;

    logic       sr [2];
    logic       rd [2];
    logic       ce [2];
    logic [7:0] lc [2];

    int n_checks;
    int n_fail;

    pll_reset_sequencer #(
        .SYNC_STAGES(SYNC), .STABLE_CYCLES(ST),
        .HOLD_CYCLES(HO), .CE_DIV(5)
    ) u_dut0 (
        .i_clock(clk), .i_reset(rst), .i_locked(lk),
        .o_sys_reset(sr[0]), .o_ready(rd[0]),
        .o_ce_tick(ce[0]), .o_lock_loss_count(lc[0])
    );

    pll_reset_sequencer #(
        .SYNC_STAGES(SYNC), .STABLE_CYCLES(ST),
        .HOLD_CYCLES(HO), .CE_DIV(1)
    ) u_dut1 (
        .i_clock(clk), .i_reset(rst), .i_locked(lk),
        .o_sys_reset(sr[1]), .o_ready(rd[1]),
        .o_ce_tick(ce[1]), .o_lock_loss_count(lc[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: RUN is reached once the synchronized lock has
    // been seen high on 1+ST+HO consecutive edges since the last low.
    // ------------------------------------------------------------------
    int  ce_div [2] = '{5, 1};
    int  streak [2];
    int  m_lc   [2];
    bit  m_run  [2];
    bit  m_tick [2];
    bit  m_valid = 1'b0;
    bit  sq [$];

    always @(posedge clk) begin
        bit ls;
        if (rst) begin
            sq.delete();
            for (int i = 0; i < SYNC; i++) sq.push_back(1'b0);
            for (int j = 0; j < 2; j++) begin
                streak[j] = 0;
                m_lc[j]   = 0;
                m_run[j]  = 1'b0;
                m_tick[j] = 1'b0;
            end
            m_valid = 1'b1;
        end else if (m_valid) begin
            ls = sq.pop_front();
            sq.push_back(lk);
            for (int j = 0; j < 2; j++) begin
                if (ls) begin
                    streak[j]++;
                end else begin
                    if (m_run[j] && m_lc[j] < 255) m_lc[j]++;
                    streak[j] = 0;
                end
                m_run[j]  = (streak[j] >= 1 + ST + HO);
                m_tick[j] = m_run[j] &&
                            (((streak[j] - ST - HO) % ce_div[j]) == 0);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, want, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            for (int j = 0; j < 2; j++) begin
                chk($sformatf("m%0d_sys_reset", j), 32'(sr[j]), 32'(!m_run[j]));
                chk($sformatf("m%0d_ready", j), 32'(rd[j]), 32'(m_run[j]));
                chk($sformatf("m%0d_ce_tick", j), 32'(ce[j]), 32'(m_tick[j]));
                chk($sformatf("m%0d_loss_cnt", j), 32'(lc[j]), 32'(m_lc[j]));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [14:0] ce_pat;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        lk       = 1'b0;
        ce_pat   = 15'b100001000010000;

        // Power-up: ready at edge 15 after reset release.
        cyc(3);
        chk("t1_reset_sr", 32'(sr[0]), 32'd1);
        chk("t1_reset_lc", 32'(lc[0]), 32'd0);
        rst = 1'b0;
        lk  = 1'b1;
        cyc(14);
        chk("t1_edge14_ready", 32'(rd[0]), 32'd0);
        chk("t1_edge14_sr", 32'(sr[0]), 32'd1);
        cyc(1);
        chk("t1_edge15_ready", 32'(rd[0]), 32'd1);
        chk("t1_edge15_sr", 32'(sr[0]), 32'd0);
        chk("t1_edge15_lc", 32'(lc[0]), 32'd0);
        for (int k = 1; k <= 15; k++) begin
            chk($sformatf("t1_ce5_run%0d", k), 32'(ce[0]),
                32'(ce_pat[k-1]));
            chk($sformatf("t6_ce1_run%0d", k), 32'(ce[1]), 32'd1);
            if (k < 15) cyc(1);
        end

        // Lock loss from RUN takes effect at edge 3.
        lk = 1'b0;
        cyc(2);
        chk("t3_edge2_ready", 32'(rd[0]), 32'd1);
        chk("t6_edge2_ce1", 32'(ce[1]), 32'd1);
        cyc(1);
        chk("t3_edge3_sr", 32'(sr[0]), 32'd1);
        chk("t3_edge3_ready", 32'(rd[0]), 32'd0);
        chk("t3_edge3_ce", 32'(ce[0]), 32'd0);
        chk("t6_edge3_ce1", 32'(ce[1]), 32'd0);
        chk("t3_edge3_lc", 32'(lc[0]), 32'd1);
        lk = 1'b1;
        cyc(14);
        chk("t3_relock14_ready", 32'(rd[0]), 32'd0);
        cyc(1);
        chk("t3_relock15_ready", 32'(rd[0]), 32'd1);
        chk("t3_relock_lc", 32'(lc[1]), 32'd1);

        // One-cycle drop while STABILIZE cnt=5 restarts the sequence.
        lk = 1'b0;
        cyc(4);
        lk = 1'b1;
        cyc(6);
        lk = 1'b0;
        cyc(1);
        lk = 1'b1;
        cyc(14);
        chk("t2_ret14_ready", 32'(rd[0]), 32'd0);
        cyc(1);
        chk("t2_ret15_ready", 32'(rd[0]), 32'd1);
        chk("t2_lc", 32'(lc[0]), 32'd2);

        // Reset pulse mid-RUN with lock held high.
        cyc(3);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("t5_sr", 32'(sr[0]), 32'd1);
        chk("t5_ready", 32'(rd[0]), 32'd0);
        chk("t5_lc", 32'(lc[0]), 32'd0);
        cyc(14);
        chk("t5_rel14_ready", 32'(rd[0]), 32'd0);
        cyc(1);
        chk("t5_rel15_ready", 32'(rd[0]), 32'd1);

        // 260 losses from RUN saturate the counter.
        for (int i = 0; i < 260; i++) begin
            lk = 1'b0;
            cyc(3 + int'($urandom_range(0, 2)));
            lk = 1'b1;
            cyc(15 + int'($urandom_range(0, 6)));
        end
        chk("t4_sat0", 32'(lc[0]), 32'd255);
        chk("t4_sat1", 32'(lc[1]), 32'd255);
        lk = 1'b0;
        cyc(4);
        chk("t4_hold255", 32'(lc[0]), 32'd255);
        lk = 1'b1;

        // Randomized lock behaviour with occasional resets.
        for (int i = 0; i < 300; i++) begin
            lk = 1'($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 40) == 0) begin
                rst = 1'b1;
                cyc(1);
                rst = 1'b0;
            end
            cyc(int'($urandom_range(1, 30)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Sits directly downstream of the iCE40 PLL wrapper and runs in the PLL output clock domain (120 MHz). It consumes the PLL's asynchronous lock indication and produces a clean synchronous system reset and a ready flag for the rest of the design. It also generates a qualified clock-enable tick for slower logic, such as the 8-bit CPU experiments, and counts lock-loss events for debug.

Parameters:
SYNC_STAGES, 2, flip-flops in the lock synchronizer chain (>=2)
STABLE_CYCLES, 1024, cycles locked must stay high continuously before the reset hold begins (>=1)
HOLD_CYCLES, 16, extra cycles sys_reset is held after lock is stable (>=1)
CE_DIV, 120, ce_tick period in clock cycles (>=1; 120 gives 1 MHz at 120 MHz)

Ports:
clock  input  1  PLL output clock; all logic on its rising edge
reset  input  1  synchronous, active-high block reset
locked  input  1  PLL lock, asynchronous to clock
sys_reset  output  1  registered system reset, active high
ready  output  1  registered; high only in RUN
ce_tick  output  1  registered one-cycle enable pulse, RUN only
lock_loss_count  output  8  saturating count of RUN->lock-lost events

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- reset has priority over everything. On the next edge:
  - state=WAIT_LOCK; synchronizer chain all 0; all counters 0.
  - sys_reset=1, ready=0, ce_tick=0, lock_loss_count=0.
- Synchronizer: locked passes through SYNC_STAGES flops; locked_s is the last stage. No other logic samples locked.
- States: WAIT_LOCK, STABILIZE, HOLD, RUN. A single counter cnt serves both STABILIZE and HOLD.
  - WAIT_LOCK: if locked_s=1, go to STABILIZE with cnt=0.
  - STABILIZE: if locked_s=0, go to WAIT_LOCK. Otherwise increment cnt; when cnt==STABLE_CYCLES-1, go to HOLD with cnt=0.
  - HOLD: if locked_s=0, go to WAIT_LOCK. Otherwise increment cnt; when cnt==HOLD_CYCLES-1, go to RUN.
  - RUN: if locked_s=0, go to WAIT_LOCK and increment lock_loss_count, saturating at 255.
- Outputs are registered from the next state, so they change on the same edge as the state.
  - sys_reset=1 in every state except RUN.
  - ready = (state==RUN) = ~sys_reset.
- Power-up latency: with locked rising before edge 1, sys_reset falls and ready rises at edge SYNC_STAGES+1+STABLE_CYCLES+HOLD_CYCLES (1043 with defaults).
- Lock loss: with locked falling before edge 1, sys_reset=1 and ready=0 at edge SYNC_STAGES+1.
- Any locked_s low during STABILIZE or HOLD restarts the full sequence. These drops are not counted in lock_loss_count.
- ce_tick:
  - The divider counter is held at 0 outside RUN.
  - In RUN, ce_tick is high in the CE_DIV-th cycle of RUN (RUN's first cycle is cycle 1), then every CE_DIV cycles.
  - CE_DIV=1 makes ce_tick a constant 1 throughout RUN.
  - ce_tick is 0 on the edge that leaves RUN.
- reset asserted mid-sequence or mid-RUN: the full return to reset values happens on the next edge; the synchronizer is cleared, so a still-high locked needs the full power-up latency again.
- lock_loss_count is cleared only by reset; relocking does not clear it.

Test Plan:
1. Params SYNC_STAGES=2, STABLE_CYCLES=8, HOLD_CYCLES=4, CE_DIV=5; reset 3 cycles, then locked=1 -> sys_reset falls and ready rises at edge 15 after the reset release; ce_tick high at RUN cycles 5, 10, 15; lock_loss_count=0.
2. Same params; locked drops for 1 cycle at STABILIZE cnt=5 -> state returns to WAIT_LOCK and the sequence restarts; sys_reset is never low in between; lock_loss_count stays 0; deassertion occurs 15 edges after locked returns high.
3. In RUN, locked=0 -> sys_reset=1, ready=0, ce_tick=0 at edge 3; lock_loss_count=1; locked=1 again -> RUN after 15 edges, count still 1.
4. Cycle lock in and out of RUN 260 times -> lock_loss_count reads 255 and holds at 255.
5. reset pulsed for 1 cycle mid-RUN with locked held high -> next edge sys_reset=1, ready=0, count=0; ready returns 15 edges after reset release.
6. CE_DIV=1 -> ce_tick=1 on every RUN cycle and 0 on the edge lock loss takes effect.
